conv_mac_array: RTL and testbench

//  Parametrised NPE-lane signed MAC array with a control FSM, bias, ReLU, requantisation and ready/valid handshakes.

---
 rtl/conv_mac_array.sv | 137 +++++++++++++
 tb/tb_conv_mac_array.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/conv_mac_array.sv
// NPE-lane signed MAC array: accumulate a programmed number of beats, then add bias,
// ReLU, requantise and hold one result set (per-lane or lane-reduced) until accepted.
module conv_mac_lane #(
  parameter int DW   = 8,
  parameter int ACCW = 24
) (
  input  logic                   Clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   en,
  input  logic signed [DW-1:0]   act,
  input  logic signed [DW-1:0]   wgt,
  output logic [ACCW-1:0]        acc
);
  logic signed [2*DW-1:0] prod;
  assign prod = act * wgt;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset)    acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
  end
endmodule

module conv_mac_array #(
  parameter int NPE        = 9,
  parameter int DW         = 8,
  parameter int ACCW       = 24,
  parameter int KMAX       = 9,
  parameter int FRAC       = 8,
  parameter int BIAS_SHIFT = 4,
  localparam int SW        = $clog2(KMAX+1)
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [SW-1:0]     steps,
  input  logic [DW-1:0]     bias,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NPE*DW-1:0] in_act,
  input  logic [NPE*DW-1:0] in_wgt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NPE*DW-1:0] out_data,
  output logic [DW-1:0]     out_sum,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, REDUCE, HOLD} state_t;
  localparam logic signed [ACCW-1:0] QMAX = ACCW'((1 << (DW-1)) - 1);

  state_t state, state_nx;
  logic                 mode_q;
  logic [SW-1:0]        steps_q, cnt, steps_cl;
  logic [DW-1:0]        bias_q;
  logic                 clr, acc_en, beat_last;
  logic [NPE-1:0][ACCW-1:0] acc;
  logic [NPE-1:0][DW-1:0]   lane_r;
  logic signed [ACCW-1:0]   b, sum;
  logic [DW-1:0]            sum_r;

  // Negative -> 0, otherwise truncating shift then clamp to the positive output range.
  function automatic logic [DW-1:0] requant(input logic signed [ACCW-1:0] r);
    logic signed [ACCW-1:0] sh;
    sh = r >>> FRAC;
    if (r < 0)          return '0;
    else if (sh > QMAX) return QMAX[DW-1:0];
    else                return sh[DW-1:0];
  endfunction

  assign steps_cl  = (steps > SW'(KMAX)) ? SW'(KMAX) : steps;
  assign clr       = (state == IDLE) && start;
  assign acc_en    = (state == ACCUM) && in_valid;
  assign beat_last = acc_en && ((cnt + SW'(1)) == steps_q);

  for (genvar i = 0; i < NPE; i++) begin : g_lane
    conv_mac_lane #(.DW(DW), .ACCW(ACCW)) u_lane (
      .Clk   (Clk),
      .reset (reset),
      .clr   (clr),
      .en    (acc_en),
      .act   (in_act[i*DW +: DW]),
      .wgt   (in_wgt[i*DW +: DW]),
      .acc   (acc[i])
    );
  end

  always_comb begin
    b   = {{(ACCW-DW){bias_q[DW-1]}}, bias_q} <<< BIAS_SHIFT;
    sum = '0;
    for (int i = 0; i < NPE; i++) begin
      sum       = sum + $signed(acc[i]);
      lane_r[i] = requant($signed(acc[i]) + b);
    end
    sum_r = requant(sum + b);
  end

  always_comb begin
    state_nx  = state;
    in_ready  = (state == ACCUM);
    out_valid = (state == HOLD);
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (start) state_nx = (steps_cl != '0) ? ACCUM : REDUCE;
      ACCUM:   if (beat_last) state_nx = REDUCE;
      REDUCE:  state_nx = HOLD;
      HOLD:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mode_q   <= 1'b0;
      steps_q  <= '0;
      bias_q   <= '0;
      cnt      <= '0;
      out_data <= '0;
      out_sum  <= '0;
    end else begin
      state <= state_nx;
      if (clr) begin
        mode_q  <= mode;
        steps_q <= steps_cl;
        bias_q  <= bias;
        cnt     <= '0;
      end
      if (acc_en) cnt <= cnt + SW'(1);
      if (state == REDUCE) begin
        out_data <= mode_q ? '0 : lane_r;
        out_sum  <= mode_q ? sum_r : '0;
      end
    end
  end
endmodule

// File: tb/tb_conv_mac_array.sv
// Directed bench for conv_mac_array: expected results are queued at issue time and a
// negedge monitor compares them on every output handshake.
module tb_conv_mac_array;
  localparam int NPE = 9, DW = 8, SW = 4;
  localparam int VW = NPE*DW;

  logic Clk = 1'b0, reset = 1'b1, start = 1'b0, mode = 1'b0;
  logic [SW-1:0] steps = '0;
  logic [DW-1:0] bias = '0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, busy;
  logic [VW-1:0] in_act = '0, in_wgt = '0, out_data;
  logic [DW-1:0] out_sum;

  typedef struct { logic [VW-1:0] d; logic [DW-1:0] s; } exp_t;
  exp_t sb[$];
  int passed = 0, total = 0;

  conv_mac_array dut (
    .Clk(Clk), .reset(reset), .start(start), .mode(mode), .steps(steps), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_wgt(in_wgt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sum(out_sum),
    .busy(busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, req);
  endtask

  function automatic logic [VW-1:0] rep(input logic [DW-1:0] v);
    return {NPE{v}};
  endfunction

  always @(negedge Clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_output", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_sum", out_sum, e.s);
      end
    end
  end

  task automatic do_start(input logic m, input logic [SW-1:0] st, input logic [DW-1:0] b);
    int n = 0;
    while (busy && n < 200) begin @(posedge Clk); #1; n++; end
    if (busy) chk("start_wait_timeout", 1, 0);
    start = 1'b1; mode = m; steps = st; bias = b;
    @(posedge Clk); #1;
    start = 1'b0;
  endtask

  task automatic beat(input logic [VW-1:0] a, input logic [VW-1:0] w);
    int n = 0;
    while (!in_ready && n < 20) begin @(posedge Clk); #1; n++; end
    if (!in_ready) chk("in_ready_timeout", 1, 0);
    in_act = a; in_wgt = w; in_valid = 1'b1;
    @(posedge Clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin @(posedge Clk); #1; n++; end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  // Issue one operation; checks out_valid is low one cycle after the last beat/start
  // edge and high the cycle after that.
  task automatic run_op(input string nm, input logic m, input logic [SW-1:0] st,
                        input logic [DW-1:0] b, input logic [VW-1:0] a, input logic [VW-1:0] w,
                        input int nbeats, input int gap, input logic [VW-1:0] ed,
                        input logic [DW-1:0] es);
    exp_t e;
    e.d = ed; e.s = es;
    sb.push_back(e);
    do_start(m, st, b);
    for (int k = 0; k < nbeats; k++) begin
      if (k != 0) repeat (gap) begin @(posedge Clk); #1; end
      beat(a, w);
    end
    chk({nm, "_lat_reduce"}, out_valid, 0);
    @(posedge Clk); #1;
    chk({nm, "_lat_hold"}, out_valid, 1);
    wait_idle();
  endtask

  initial begin
    logic [VW-1:0] a3, w3, rnd;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_flags", {in_ready, out_valid, busy}, 0);
    reset = 1'b0;
    @(posedge Clk); #1;

    run_op("t1", 0, 1, 8'd0, rep(8'd16), rep(8'd32), 1, 0, rep(8'd2), 8'd0);
    run_op("t2", 1, 1, 8'd16, rep(8'd16), rep(8'd16), 1, 0, '0, 8'd10);

    a3 = rep(8'd4); a3[7:0] = 8'hF0;
    w3 = rep(8'd64); w3[7:0] = 8'd32;
    run_op("t3", 0, 2, 8'd0, a3, w3, 2, 3, {rep(8'd2)} & ~VW'(8'hFF), 8'd0);

    run_op("t4_sat", 1, 9, 8'd0, rep(8'd127), rep(8'd127), 9, 0, '0, 8'd127);
    run_op("t4_bias", 1, 0, 8'd32, '0, '0, 0, 0, '0, 8'd2);
    // steps above KMAX must behave as KMAX beats: 9*256 >>> 8 = 9
    run_op("clamp", 0, 15, 8'd0, rep(8'd16), rep(8'd16), 9, 0, rep(8'd9), 8'd0);

    // Back-pressure: result held while out_ready is low, start and inputs ignored.
    out_ready = 1'b0;
    begin
      exp_t e;
      e.d = rep(8'd2); e.s = 8'd0;
      sb.push_back(e);
    end
    do_start(0, 1, 8'd0);
    beat(rep(8'd16), rep(8'd32));
    @(posedge Clk); #1;
    for (int k = 0; k < 5; k++) begin
      rnd = {$urandom, $urandom, $urandom};
      start = 1'b1; in_valid = 1'b1; in_act = rnd; in_wgt = ~rnd;
      @(posedge Clk); #1;
      chk("t5_valid_held", out_valid, 1);
      chk("t5_in_ready", in_ready, 0);
      chk("t5_data_stable", out_data, rep(8'd2));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    chk("t5_valid_drop", out_valid, 0);
    chk("t5_start_ignored", busy, 0);

    // Reset mid-operation aborts it and clears everything.
    do_start(0, 9, 8'd0);
    for (int k = 0; k < 3; k++) beat(rep(8'd100), rep(8'd100));
    #2 reset = 1'b1;
    #1;
    chk("t6_out_data", out_data, 0);
    chk("t6_out_sum", out_sum, 0);
    chk("t6_flags", {in_ready, out_valid, busy}, 0);
    @(posedge Clk); #1;
    reset = 1'b0;
    @(posedge Clk); #1;
    run_op("t6_next", 0, 1, 8'd0, rep(8'd16), rep(8'd32), 1, 0, rep(8'd2), 8'd0);

    repeat (3) @(posedge Clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
